// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory
// manager. The arbiter uses the slave view; masters and memory use master.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0
  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic              ack0_o;
  // requester 1
  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              ack1_o;
  // shared response / status
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;
  logic              err_o;
  // memory manager side
  logic [ADDR_W-1:0] mem_address_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_wren_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    input  mem_data_i,
    output ack0_o, ack1_o, rdata_o, busy_o, err_o,
    output mem_address_o, mem_data_o, mem_wren_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    output mem_data_i,
    input  ack0_o, ack1_o, rdata_o, busy_o, err_o,
    input  mem_address_o, mem_data_o, mem_wren_o
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory
// manager. One transaction at a time; reads wait a fixed READ_LAT cycles.
// Optional macro ADDR_CHECK_EN: addresses >= ADDR_LIMIT are rejected with
// err_o instead of being forwarded to memory.
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
`ifdef ADDR_CHECK_EN
  ,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h30000)
`endif
) (
  input logic                CLK,
  input logic                RST_N,
  data_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LD = 4'(READ_LAT);

  state_t            state;
  logic [3:0]        cnt;
  logic              win;   // port owning the current transaction
  logic              last;  // port served most recently

  logic              any_req;
  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  // Pick the winner: a lone requester wins, otherwise the port not served last.
  always_comb begin
    any_req   = bus.req0_i | bus.req1_i;
    gnt       = 1'b0;
    if (bus.req0_i && bus.req1_i) gnt = ~last;
    else if (bus.req1_i)          gnt = 1'b1;
    sel_we    = gnt ? bus.we1_i    : bus.we0_i;
    sel_addr  = gnt ? bus.addr1_i  : bus.addr0_i;
    sel_wdata = gnt ? bus.wdata1_i : bus.wdata0_i;
`ifdef ADDR_CHECK_EN
    addr_bad  = (sel_addr >= ADDR_LIMIT);
`else
    addr_bad  = 1'b0;
`endif
  end

  // Transaction FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= IDLE;
      cnt               <= '0;
      win               <= 1'b0;
      last              <= 1'b1;
      bus.ack0_o        <= 1'b0;
      bus.ack1_o        <= 1'b0;
      bus.mem_wren_o    <= 1'b0;
      bus.busy_o        <= 1'b0;
      bus.err_o         <= 1'b0;
      bus.rdata_o       <= '0;
      bus.mem_address_o <= '0;
      bus.mem_data_o    <= '0;
    end else begin
      bus.ack0_o     <= 1'b0;
      bus.ack1_o     <= 1'b0;
      bus.err_o      <= 1'b0;
      bus.mem_wren_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win        <= gnt;
            bus.busy_o <= 1'b1;
            if (addr_bad) begin
              // rejected access: answer straight away, memory untouched
              state       <= RESP;
              bus.ack0_o  <= ~gnt;
              bus.ack1_o  <= gnt;
              bus.err_o   <= 1'b1;
              bus.rdata_o <= '0;
            end else begin
              bus.mem_address_o <= sel_addr;
              bus.mem_data_o    <= sel_wdata;
              if (sel_we) begin
                state          <= WR;
                bus.mem_wren_o <= 1'b1;
              end else begin
                state <= RD_WAIT;
                cnt   <= LAT_LD;
              end
            end
          end
        end
        WR: begin
          state      <= RESP;
          bus.ack0_o <= ~win;
          bus.ack1_o <= win;
        end
        RD_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= RESP;
            bus.rdata_o <= bus.mem_data_i;
            bus.ack0_o  <= ~win;
            bus.ack1_o  <= win;
          end
        end
        RESP: begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
          last       <= win;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a one-cycle synchronous
// memory model standing in for the data memory manager.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [31:0] mem [0:4095];

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] idx(input logic [31:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  // memory model: write on wren, registered read of the presented address
  always @(posedge CLK) begin
    if (bus.mem_wren_o) mem[idx(bus.mem_address_o)] <= bus.mem_data_o;
    bus.mem_data_i <= mem[idx(bus.mem_address_o)];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_i = 1'b1; bus.we0_i = we; bus.addr0_i = a; bus.wdata0_i = d;
    end else begin
      bus.req1_i = 1'b1; bus.we1_i = we; bus.addr1_i = a; bus.wdata1_i = d;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) bus.req0_i = 1'b0;
    else        bus.req1_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ack0"},  bus.ack0_o, 0);
    check({tag, " ack1"},  bus.ack1_o, 0);
    check({tag, " wren"},  bus.mem_wren_o, 0);
    check({tag, " busy"},  bus.busy_o, 0);
    check({tag, " err"},   bus.err_o, 0);
    check({tag, " rdata"}, bus.rdata_o, 0);
    check({tag, " maddr"}, bus.mem_address_o, 0);
    check({tag, " mdata"}, bus.mem_data_o, 0);
  endtask

  // Single transaction from an IDLE negedge; ack expected lat cycles after the request.
  task automatic txn(input string tag, input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input logic [31:0] exp_rd,
                     input logic exp_err);
    set_req(p, we, a, d);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge CLK);
      check($sformatf("%s ack0 c%0d", tag, c), bus.ack0_o, (p == 0 && c == lat));
      check($sformatf("%s ack1 c%0d", tag, c), bus.ack1_o, (p == 1 && c == lat));
      check($sformatf("%s wren c%0d", tag, c), bus.mem_wren_o, (we && c == 1));
      check($sformatf("%s busy c%0d", tag, c), bus.busy_o, (c <= lat));
      if (we && c == 1) begin
        check($sformatf("%s maddr", tag), bus.mem_address_o, a);
        check($sformatf("%s mdata", tag), bus.mem_data_o, d);
      end
      if (c == lat) begin
        check($sformatf("%s err", tag), bus.err_o, exp_err);
        check($sformatf("%s rdata", tag), bus.rdata_o, exp_rd);
        drop_req(p);
      end
    end
  endtask

  initial begin
    bus.req0_i = 1'b0; bus.we0_i = 1'b0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = '0; bus.wdata1_i = '0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // port 0 write 5 -> 5
    txn("t1", 0, 1'b1, 32'h5, 32'h5, 2, 32'h0, 1'b0);

    // port 1 write then read 0x10003
    txn("t2w", 1, 1'b1, 32'h10003, 32'h10003, 2, 32'h0, 1'b0);
    txn("t2r", 1, 1'b0, 32'h10003, 32'h0, 3, 32'h10003, 1'b0);

    // simultaneous reads after reset: port 0 first, then port 1
    txn("t3w0", 0, 1'b1, 32'h20001, 32'hA5A50001, 2, 32'h10003, 1'b0);
    txn("t3w1", 1, 1'b1, 32'h20002, 32'h5A5A0002, 2, 32'h10003, 1'b0);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    set_req(0, 1'b0, 32'h20001, 32'h0);
    set_req(1, 1'b0, 32'h20002, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      check($sformatf("t3 ack0 c%0d", c), bus.ack0_o, (c == 3));
      check($sformatf("t3 ack1 c%0d", c), bus.ack1_o, (c == 7));
      check($sformatf("t3 dual c%0d", c), bus.ack0_o & bus.ack1_o, 0);
      check($sformatf("t3 wren c%0d", c), bus.mem_wren_o, 0);
      check($sformatf("t3 busy c%0d", c), bus.busy_o, (c != 4 && c != 8));
      if (c == 3) begin
        check("t3 rdata0", bus.rdata_o, 32'hA5A50001);
        drop_req(0);
      end
      if (c == 7) begin
        check("t3 rdata1", bus.rdata_o, 32'h5A5A0002);
        drop_req(1);
      end
    end

    // both ports hold req: grants alternate 0,1,0,1 with one IDLE gap each
    set_req(0, 1'b1, 32'h100, 32'h11110000);
    set_req(1, 1'b1, 32'h200, 32'h22220000);
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      check($sformatf("t4 ack0 c%0d", c), bus.ack0_o, (c % 3 == 2 && (c / 3) % 2 == 0 && c <= 11));
      check($sformatf("t4 ack1 c%0d", c), bus.ack1_o, (c % 3 == 2 && (c / 3) % 2 == 1 && c <= 11));
      check($sformatf("t4 busy c%0d", c), bus.busy_o, (c % 3 != 0 && c <= 11));
      check($sformatf("t4 wren c%0d", c), bus.mem_wren_o, (c % 3 == 1 && c <= 10));
      if (c % 3 == 1 && c <= 10)
        check($sformatf("t4 maddr c%0d", c), bus.mem_address_o,
              ((c / 3) % 2 == 0) ? 32'h100 : 32'h200);
      if (c == 11) begin
        drop_req(0);
        drop_req(1);
      end
    end

    // reset during RD_WAIT drops the read
    set_req(0, 1'b0, 32'h20001, 32'h0);
    @(negedge CLK);
    check("t5 busy pre", bus.busy_o, 1);
    RST_N = 1'b0;
    drop_req(0);
    #1;
    check_all_zero("t5 async");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      check($sformatf("t5 noack0 c%0d", c), bus.ack0_o, 0);
      check($sformatf("t5 noack1 c%0d", c), bus.ack1_o, 0);
      check($sformatf("t5 idle c%0d", c), bus.busy_o, 0);
    end
    txn("t5r", 0, 1'b0, 32'h10003, 32'h0, 3, 32'h10003, 1'b0);

    // access at the address limit
`ifdef ADDR_CHECK_EN
    txn("t6", 1, 1'b0, 32'h30000, 32'h0, 1, 32'h0, 1'b1);
`else
    txn("t6w", 1, 1'b1, 32'h30000, 32'hC0DE0030, 2, 32'h10003, 1'b0);
    txn("t6r", 1, 1'b0, 32'h30000, 32'h0, 3, 32'hC0DE0030, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
